pr_freeze_drain_bridge: RTL and testbench



---
 rtl/pr_freeze_drain_bridge.sv | 165 ++++++++++++++++
 tb/tb_pr_freeze_drain_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_freeze_drain_bridge.sv
// pr_freeze_drain_bridge
//   Avalon-MM pass-through between a partial-reconfiguration region master
//   (s_*) and the static-region EMIF port (m_*). It owns the PR freeze
//   handshake:
//   - A stop request closes the command gate.
//   - In-flight write bursts and outstanding read beats are then drained.
//   - The bridge then reports frozen.
//   - A start request is only acknowledged from the frozen state.
//   Outstanding read beats are counted so that reads can be throttled. A
//   readdatavalid that arrives with nothing outstanding is flagged.
//
// Ports
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   pr_handshake_start_req/_ack     4-phase resume handshake
//   pr_handshake_stop_req/_ack      4-phase freeze handshake
//   s_*                             reconfigurable-region Avalon-MM slave
//   m_*                             EMIF-side Avalon-MM master
//   frozen                          high whenever the bridge is not in RUN
//   err_stray_rdv                   sticky: m_readdatavalid with none outstanding
module pr_freeze_drain_bridge #(
   parameter int DATA_W          = 512,
   parameter int ADDR_W          = 31,
   parameter int BURST_W         = 5,
   parameter int MAX_OUTSTANDING = 64
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic                  pr_handshake_start_req,
   output logic                  pr_handshake_start_ack,
   input  logic                  pr_handshake_stop_req,
   output logic                  pr_handshake_stop_ack,
   input  logic                  s_read,
   input  logic                  s_write,
   input  logic [ADDR_W-1:0]     s_address,
   input  logic [BURST_W-1:0]    s_burstcount,
   input  logic [DATA_W-1:0]     s_writedata,
   input  logic [DATA_W/8-1:0]   s_byteenable,
   output logic                  s_waitrequest,
   output logic [DATA_W-1:0]     s_readdata,
   output logic                  s_readdatavalid,
   output logic                  m_read,
   output logic                  m_write,
   output logic [ADDR_W-1:0]     m_address,
   output logic [BURST_W-1:0]    m_burstcount,
   output logic [DATA_W-1:0]     m_writedata,
   output logic [DATA_W/8-1:0]   m_byteenable,
   input  logic                  m_waitrequest,
   input  logic [DATA_W-1:0]     m_readdata,
   input  logic                  m_readdatavalid,
   output logic                  frozen,
   output logic                  err_stray_rdv
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_DRAIN     = 2'd1,
      ST_FROZEN    = 2'd2,
      ST_ACK_START = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     rd_cnt_reg, rd_cnt_next;
   logic [BURST_W-1:0]   wr_left_reg, wr_left_next;
   logic                 init_done_reg;
   logic                 err_reg, err_next;

   logic [BURST_W-1:0]   eff_burst;
   logic [CNT_W:0]       rd_sum;
   logic                 rd_throttle;
   logic                 run_open, wr_busy, gate_rd, gate_wr, gate;
   logic                 rd_acc, wr_acc, rd_dec;
   logic [CNT_W-1:0]     rd_add;

   // A burstcount of zero is illegal on Avalon; it is handled as a single beat.
   assign eff_burst = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

   // The sum is one bit wider than the counter, so the throttle compare
   // cannot wrap.
   assign rd_sum      = {1'b0, rd_cnt_reg} + (CNT_W+1)'(eff_burst);
   assign rd_throttle = rd_sum > (CNT_W+1)'(MAX_OUTSTANDING);

   // init_done_reg keeps the gate shut for the first cycle after reset release.
   assign run_open = init_done_reg && (state_reg == ST_RUN);
   assign wr_busy  = (wr_left_reg != '0);
   // A write burst that is already started must finish, even while draining.
   assign gate_wr  = (run_open || wr_busy) && (state_reg != ST_FROZEN);
   assign gate_rd  = run_open && !wr_busy && !rd_throttle;
   assign gate     = s_read ? gate_rd : gate_wr;

   assign m_read        = s_read  && gate_rd;
   assign m_write       = s_write && gate_wr;
   assign m_address     = s_address;
   assign m_burstcount  = eff_burst;
   assign m_writedata   = s_writedata;
   assign m_byteenable  = BE_W'(s_byteenable);
   assign s_waitrequest = m_waitrequest || !gate;

   assign s_readdata      = m_readdata;
   assign s_readdatavalid = m_readdatavalid;

   assign rd_acc = m_read  && !m_waitrequest;
   assign wr_acc = m_write && !m_waitrequest;
   // A stray beat with nothing outstanding must not wrap the counter.
   assign rd_dec = m_readdatavalid && (rd_cnt_reg != '0);
   assign rd_add = rd_acc ? CNT_W'(eff_burst) : '0;

   always_comb begin
      rd_cnt_next  = rd_cnt_reg + rd_add - CNT_W'(rd_dec);
      err_next     = err_reg || (m_readdatavalid && (rd_cnt_reg == '0));
      wr_left_next = wr_left_reg;
      if (wr_acc) begin
         if (wr_busy) begin
            wr_left_next = wr_left_reg - BURST_W'(1);
         end else begin
            wr_left_next = eff_burst - BURST_W'(1);
         end
      end
   end

   // A stop request takes priority over a start request in every state.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN: begin
            if (pr_handshake_stop_req) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (rd_cnt_reg == '0 && !wr_busy) state_next = ST_FROZEN;
         end
         ST_FROZEN: begin
            if (!pr_handshake_stop_req && pr_handshake_start_req) state_next = ST_ACK_START;
         end
         ST_ACK_START: begin
            if (pr_handshake_stop_req)        state_next = ST_DRAIN;
            else if (!pr_handshake_start_req) state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_reg     <= ST_RUN;
         rd_cnt_reg    <= '0;
         wr_left_reg   <= '0;
         init_done_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rd_cnt_reg    <= rd_cnt_next;
         wr_left_reg   <= wr_left_next;
         init_done_reg <= 1'b1;
         err_reg       <= err_next;
      end
   end

   assign pr_handshake_stop_ack  = (state_reg == ST_FROZEN) && pr_handshake_stop_req;
   assign pr_handshake_start_ack = (state_reg == ST_ACK_START);
   assign frozen                 = (state_reg != ST_RUN);
   assign err_stray_rdv          = err_reg;

endmodule

// File: tb/tb_pr_freeze_drain_bridge.sv
// Directed bench for pr_freeze_drain_bridge. The downstream EMIF side is
// driven by hand. Expected values are worked out from the handshake and the
// read/write accounting rules.
module tb_pr_freeze_drain_bridge;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 31;
   localparam int BURST_W = 5;
   localparam int MAX_OUT = 64;

   logic                 clk_clk = 1'b0;
   logic                 reset_reset_n;
   logic                 start_req, start_ack, stop_req, stop_ack;
   logic                 s_read, s_write, s_waitrequest, s_readdatavalid;
   logic [ADDR_W-1:0]    s_address, m_address;
   logic [BURST_W-1:0]   s_burstcount, m_burstcount;
   logic [DATA_W-1:0]    s_writedata, s_readdata, m_writedata, m_readdata;
   logic [DATA_W/8-1:0]  s_byteenable, m_byteenable;
   logic                 m_read, m_write, m_waitrequest, m_readdatavalid;
   logic                 frozen, err_stray_rdv;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk_clk = ~clk_clk;

   pr_freeze_drain_bridge #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .pr_handshake_start_req(start_req), .pr_handshake_start_ack(start_ack),
      .pr_handshake_stop_req(stop_req), .pr_handshake_stop_ack(stop_ack),
      .s_read(s_read), .s_write(s_write), .s_address(s_address),
      .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_burstcount(m_burstcount),
      .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
      .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .frozen(frozen), .err_stray_rdv(err_stray_rdv)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, obs);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks follow another 1 ns later.
   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic resume();
      stop_req  = 1'b0;
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      step();
   endtask

   initial begin
      reset_reset_n   = 1'b0;
      start_req       = 1'b0;
      stop_req        = 1'b0;
      s_read          = 1'b0;
      s_write         = 1'b0;
      s_address       = 31'h100;
      s_burstcount    = 5'd1;
      s_writedata     = 32'hA5A5_0000;
      s_byteenable    = 4'hF;
      m_waitrequest   = 1'b0;
      m_readdata      = '0;
      m_readdatavalid = 1'b0;

      // Reset state
      #12;
      check_eq("rst_frozen", frozen, 1'b0);
      check_eq("rst_stop_ack", stop_ack, 1'b0);
      check_eq("rst_start_ack", start_ack, 1'b0);
      check_eq("rst_err", err_stray_rdv, 1'b0);
      check_eq("rst_rdv", s_readdatavalid, 1'b0);
      repeat (2) @(posedge clk_clk);
      #1 reset_reset_n = 1'b1;
      #1;
      check_eq("first_cycle_wait", s_waitrequest, 1'b1);
      check_eq("first_cycle_mwrite", m_write, 1'b0);
      step();
      check_eq("after_first_wait", s_waitrequest, 1'b0);

      // T1: stop request with an idle bus
      stop_req = 1'b1;
      step();
      check_eq("t1_drain_frozen", frozen, 1'b1);
      check_eq("t1_drain_ack", stop_ack, 1'b0);
      step();
      check_eq("t1_frozen_ack", stop_ack, 1'b1);
      stop_req = 1'b0;
      #1;
      check_eq("t1_ack_drop", stop_ack, 1'b0);
      check_eq("t1_still_frozen", frozen, 1'b1);
      start_req = 1'b1;
      step();
      check_eq("t6_start_ack", start_ack, 1'b1);
      start_req = 1'b0;
      step();
      check_eq("t6_start_ack_drop", start_ack, 1'b0);
      check_eq("t6_run", frozen, 1'b0);

      // T2: 16-beat read outstanding while stopping
      s_read = 1'b1;
      s_burstcount = 5'd16;
      #1;
      check_eq("t2_mread", m_read, 1'b1);
      check_eq("t2_mburst", m_burstcount, 5'd16);
      step();
      s_read = 1'b0;
      stop_req = 1'b1;
      step();
      s_read = 1'b1;
      s_burstcount = 5'd1;
      #1;
      check_eq("t2_drain_mread", m_read, 1'b0);
      check_eq("t2_drain_wait", s_waitrequest, 1'b1);
      s_read = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_readdatavalid = 1'b1;
         m_readdata = 32'hD000 + i;
         #1;
         check_eq($sformatf("t2_rdv%0d", i), s_readdatavalid, 1'b1);
         check_eq($sformatf("t2_rdata%0d", i), s_readdata, 32'hD000 + i);
         check_eq($sformatf("t2_noack%0d", i), stop_ack, 1'b0);
         step();
      end
      m_readdatavalid = 1'b0;
      #1;
      check_eq("t2_noack_end", stop_ack, 1'b0);
      step();
      check_eq("t2_stop_ack", stop_ack, 1'b1);
      check_eq("t2_err_clean", err_stray_rdv, 1'b0);
      resume();
      check_eq("t2_resumed", frozen, 1'b0);

      // T3: 8-beat write, stop after beat 3
      s_write = 1'b1;
      s_burstcount = 5'd8;
      for (int b = 1; b <= 8; b++) begin
         s_writedata = 32'hB000 + b;
         if (b == 4) stop_req = 1'b1;
         if (b == 5) begin
            s_write = 1'b0;
            s_read = 1'b1;
            s_burstcount = 5'd1;
            #1;
            check_eq("t3_read_mread", m_read, 1'b0);
            check_eq("t3_read_wait", s_waitrequest, 1'b1);
            s_read = 1'b0;
            s_write = 1'b1;
         end
         #1;
         check_eq($sformatf("t3_mwrite%0d", b), m_write, 1'b1);
         check_eq($sformatf("t3_wdata%0d", b), m_writedata, 32'hB000 + b);
         step();
      end
      #1;
      check_eq("t3_post_mwrite", m_write, 1'b0);
      check_eq("t3_post_wait", s_waitrequest, 1'b1);
      check_eq("t3_post_ack", stop_ack, 1'b0);
      s_write = 1'b0;
      step();
      check_eq("t3_stop_ack", stop_ack, 1'b1);
      resume();

      // T4: read throttle at 64 outstanding beats
      for (int k = 0; k < 4; k++) begin
         s_read = 1'b1;
         s_burstcount = 5'd16;
         #1;
         check_eq($sformatf("t4_read%0d", k), m_read, 1'b1);
         step();
      end
      s_burstcount = 5'd1;
      #1;
      check_eq("t4_stall_mread", m_read, 1'b0);
      check_eq("t4_stall_wait", s_waitrequest, 1'b1);
      s_read = 1'b0;
      s_write = 1'b1;
      #1;
      check_eq("t4_write_open", m_write, 1'b1);
      s_write = 1'b0;
      s_read = 1'b1;
      step();
      m_readdatavalid = 1'b1;
      #1;
      check_eq("t4_stall_rdv_cycle", m_read, 1'b0);
      step();
      m_readdatavalid = 1'b0;
      #1;
      check_eq("t4_release", m_read, 1'b1);
      check_eq("t4_release_wait", s_waitrequest, 1'b0);
      step();
      s_read = 1'b0;
      m_readdatavalid = 1'b1;
      repeat (64) step();
      m_readdatavalid = 1'b0;
      check_eq("t4_no_stray", err_stray_rdv, 1'b0);

      // T6: simultaneous stop and start
      stop_req = 1'b1;
      step();
      step();
      check_eq("t6_frozen_ack", stop_ack, 1'b1);
      start_req = 1'b1;
      step();
      check_eq("t6_both_stays", stop_ack, 1'b1);
      check_eq("t6_both_no_start", start_ack, 1'b0);
      stop_req = 1'b0;
      step();
      check_eq("t6_ack_start", start_ack, 1'b1);
      stop_req = 1'b1;
      step();
      check_eq("t6_restop_start_ack", start_ack, 1'b0);
      check_eq("t6_restop_frozen", frozen, 1'b1);
      step();
      check_eq("t6_refrozen", stop_ack, 1'b1);
      resume();
      check_eq("t6_final_run", frozen, 1'b0);

      // T5: stray readdatavalid
      m_readdatavalid = 1'b1;
      step();
      m_readdatavalid = 1'b0;
      #1;
      check_eq("t5_err_set", err_stray_rdv, 1'b1);
      step();
      check_eq("t5_err_held", err_stray_rdv, 1'b1);
      stop_req = 1'b1;
      step();
      step();
      check_eq("t5_cnt_zero_freeze", stop_ack, 1'b1);
      stop_req = 1'b0;
      reset_reset_n = 1'b0;
      #1;
      check_eq("t5_rst_err", err_stray_rdv, 1'b0);
      check_eq("t5_rst_frozen", frozen, 1'b0);
      step();
      reset_reset_n = 1'b1;
      step();
      m_readdatavalid = 1'b1;
      step();
      m_readdatavalid = 1'b0;
      #1;
      check_eq("t5_late_rdv_err", err_stray_rdv, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
